// File: rtl/fpu_pipe_if.sv
// rtl/fpu_pipe_if.sv - operand issue / result writeback handshake bundle for fpu_pipe
interface fpu_pipe_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     A;
  logic [W-1:0]     B;
  logic [1:0]       opcode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     outp;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;

  modport master (
    output in_valid, A, B, opcode, in_tag, out_ready,
    input  in_ready, out_valid, outp, out_tag, flags
  );

  modport slave (
    input  in_valid, A, B, opcode, in_tag, out_ready,
    output in_ready, out_valid, outp, out_tag, flags
  );
endinterface

// File: rtl/fpu_pipe.sv
// rtl/fpu_pipe.sv - pipelined FP add/sub/mul, RNE rounding, FTZ, tag pass-through, exception flags
module fpu_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 4
) (
  input logic       clk,
  input logic       rst,
  fpu_pipe_if.slave io
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M   = MAN_W + 1;
  localparam int AW  = M + 3;
  localparam int EW  = EXP_W + 2;
  localparam int H   = M / 2;
  localparam int PL  = M + H;
  localparam int PH  = 2 * M - H;
  localparam int LZW = $clog2(AW + 2);
  localparam int SHW = $clog2(AW + 1);
  localparam logic [EXP_W-1:0] EMAX = '1;
  localparam logic [EW-1:0]    BIAS = EW'(2**(EXP_W-1) - 1);
  localparam logic [W-1:0]     QNAN = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};

  logic stall, adv;
  assign stall       = io.out_valid && !io.out_ready;
  assign adv         = !stall;
  assign io.in_ready = adv;

  logic sa, sb, sbe, is_mul, swap;
  logic zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic [EXP_W-1:0] ea, eb, big_e, sml_e, dexp;
  logic [MAN_W-1:0] fa, fb;
  logic [EXP_W+MAN_W-1:0] key_a, key_b;
  logic [M-1:0] ma, mb, big_m, sml_m;
  logic [SHW-1:0] sh;
  logic [2*AW-1:0] ext;
  logic sp, sp_inv;
  logic [W-1:0] sp_val;

  assign {sa, ea, fa} = io.A;
  assign {sb, eb, fb} = io.B;
  assign zero_a = (ea == '0);
  assign zero_b = (eb == '0);
  assign inf_a  = (ea == EMAX) && (fa == '0);
  assign inf_b  = (eb == EMAX) && (fb == '0);
  assign nan_a  = (ea == EMAX) && (fa != '0);
  assign nan_b  = (eb == EMAX) && (fb != '0);
  assign is_mul = (io.opcode == 2'b10);
  assign sbe    = sb ^ (io.opcode == 2'b01);
  assign ma     = zero_a ? '0 : {1'b1, fa};
  assign mb     = zero_b ? '0 : {1'b1, fb};
  assign key_a  = zero_a ? '0 : {ea, fa};
  assign key_b  = zero_b ? '0 : {eb, fb};
  assign swap   = key_a < key_b;
  assign big_e  = swap ? eb : ea;
  assign sml_e  = swap ? ea : eb;
  assign big_m  = swap ? mb : ma;
  assign sml_m  = swap ? ma : mb;
  assign dexp   = big_e - sml_e;
  assign sh     = (dexp > EXP_W'(AW)) ? SHW'(AW) : SHW'(dexp);
  // low half of ext collects every bit shifted past the guard/round positions
  assign ext    = {sml_m, 3'b000, {AW{1'b0}}} >> sh;

  always_comb begin
    sp     = 1'b0;
    sp_inv = 1'b0;
    sp_val = '0;
    if (nan_a || nan_b || (io.opcode == 2'b11) ||
        (is_mul && ((zero_a && inf_b) || (inf_a && zero_b))) ||
        (!is_mul && inf_a && inf_b && (sa != sbe))) begin
      sp     = 1'b1;
      sp_inv = 1'b1;
      sp_val = QNAN;
    end else if (inf_a || inf_b) begin
      sp     = 1'b1;
      sp_val = {(is_mul ? (sa ^ sb) : (inf_a ? sa : sbe)), EMAX, {MAN_W{1'b0}}};
    end else if (is_mul && (zero_a || zero_b)) begin
      sp     = 1'b1;
      sp_val = {sa ^ sb, {(W-1){1'b0}}};
    end
  end

  logic r1_v, r1_sp, r1_inv, r1_mul, r1_sign, r1_sub, r1_zsign;
  logic [TAG_W-1:0] r1_tag;
  logic [W-1:0] r1_sp_val;
  logic [EW-1:0] r1_exp;
  logic [AW-1:0] r1_big, r1_sml;
  logic [PL-1:0] r1_pp_lo;
  logic [PH-1:0] r1_pp_hi;

  logic r2_v, r2_sp, r2_inv, r2_mul, r2_sign, r2_zsign;
  logic [TAG_W-1:0] r2_tag;
  logic [W-1:0] r2_sp_val;
  logic [EW-1:0] r2_exp;
  logic [AW:0] r2_sum;
  logic [2*M-1:0] r2_prod;

  logic r3_v, r3_sp, r3_inv, r3_sign, r3_zero, r3_zsign, r3_g, r3_s;
  logic [TAG_W-1:0] r3_tag;
  logic [W-1:0] r3_sp_val;
  logic [M-1:0] r3_nm;
  logic [EW-1:0] r3_ne;

  logic [LZW-1:0] lz;
  logic [AW:0] sum_n;
  logic [2*M-1:0] prod_n;
  logic [M-1:0] nm;
  logic g, s;
  logic [EW-1:0] ne;

  always_comb begin
    lz = LZW'(AW + 1);
    for (int i = 0; i <= AW; i++) begin
      if (r2_sum[i]) lz = LZW'(AW - i);
    end
    sum_n  = r2_sum << lz;
    prod_n = r2_prod[2*M-1] ? r2_prod : (r2_prod << 1);
    if (r2_mul) begin
      nm = prod_n[2*M-1:M];
      g  = prod_n[M-1];
      s  = |prod_n[M-2:0];
      ne = r2_exp + EW'(r2_prod[2*M-1]);
    end else begin
      nm = sum_n[AW:4];
      g  = sum_n[3];
      s  = |sum_n[2:0];
      ne = r2_exp + EW'(1) - EW'(lz);
    end
  end

  logic inc;
  logic [M:0] mr;
  logic [EW-1:0] re;
  logic [MAN_W-1:0] frac;
  logic [W-1:0] res;
  logic [3:0] fl;

  assign inc  = r3_g & (r3_s | r3_nm[0]);
  assign mr   = {1'b0, r3_nm} + (M+1)'(inc);
  assign re   = r3_ne + EW'(mr[M]);
  assign frac = mr[M] ? mr[MAN_W:1] : mr[MAN_W-1:0];

  always_comb begin
    res = {r3_sign, re[EXP_W-1:0], frac};
    fl  = 4'b0000;
    if (r3_sp) begin
      res = r3_sp_val;
      fl  = {r3_inv, 3'b000};
    end else if (r3_zero) begin
      res = {r3_zsign, {(W-1){1'b0}}};
    end else if ($signed(re) >= $signed({2'b00, EMAX})) begin
      res = {r3_sign, EMAX, {MAN_W{1'b0}}};
      fl  = 4'b0101;
    end else if ($signed(re) <= $signed(EW'(0))) begin
      res = {r3_sign, {(W-1){1'b0}}};
      fl  = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_v         <= 1'b0;
      r2_v         <= 1'b0;
      r3_v         <= 1'b0;
      io.out_valid <= 1'b0;
      io.outp      <= '0;
      io.out_tag   <= '0;
      io.flags     <= '0;
    end else if (adv) begin
      r1_v      <= io.in_valid;
      r1_tag    <= io.in_tag;
      r1_sp     <= sp;
      r1_sp_val <= sp_val;
      r1_inv    <= sp_inv;
      r1_mul    <= is_mul;
      r1_sign   <= is_mul ? (sa ^ sb) : (swap ? sbe : sa);
      r1_sub    <= sa ^ sbe;
      r1_zsign  <= sa & sbe;
      r1_exp    <= is_mul ? (EW'(ea) + EW'(eb) - BIAS) : EW'(big_e);
      r1_big    <= {big_m, 3'b000};
      r1_sml    <= {ext[2*AW-1:AW+1], ext[AW] | (|ext[AW-1:0])};
      r1_pp_lo  <= PL'(ma) * PL'(mb[H-1:0]);
      r1_pp_hi  <= PH'(ma) * PH'(mb[M-1:H]);

      r2_v      <= r1_v;
      r2_tag    <= r1_tag;
      r2_sp     <= r1_sp;
      r2_sp_val <= r1_sp_val;
      r2_inv    <= r1_inv;
      r2_mul    <= r1_mul;
      r2_sign   <= r1_sign;
      r2_zsign  <= r1_zsign;
      r2_exp    <= r1_exp;
      r2_sum    <= r1_sub ? ({1'b0, r1_big} - {1'b0, r1_sml}) : ({1'b0, r1_big} + {1'b0, r1_sml});
      r2_prod   <= (2*M)'(r1_pp_lo) + ((2*M)'(r1_pp_hi) << H);

      r3_v      <= r2_v;
      r3_tag    <= r2_tag;
      r3_sp     <= r2_sp;
      r3_sp_val <= r2_sp_val;
      r3_inv    <= r2_inv;
      r3_sign   <= r2_sign;
      r3_zero   <= !r2_mul && (r2_sum == '0);
      r3_zsign  <= r2_zsign;
      r3_nm     <= nm;
      r3_g      <= g;
      r3_s      <= s;
      r3_ne     <= ne;

      io.out_valid <= r3_v;
      io.outp      <= res;
      io.out_tag   <= r3_tag;
      io.flags     <= fl;
    end
  end
endmodule
